// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the key debouncer.
package debounce_pkg;

    localparam int DEB_CLK_CYC_NS = 10;
    localparam int DEB_TIME_NS    = 10_000_000;

    // Width of a counter that must hold 0 .. deb_cnt-1.
    function automatic int deb_cnt_width(input int deb_cnt);
        return (deb_cnt < 2) ? 1 : $clog2(deb_cnt);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/key_debounce.sv
// Debounces an active-low key into a clean level plus one-cycle press/release strobes.
module key_debounce
    import debounce_pkg::*;
#(
    parameter int CLK_CYC     = debounce_pkg::DEB_CLK_CYC_NS,
    parameter int DEB_TIME_NS = debounce_pkg::DEB_TIME_NS
) (
    input  logic sysclk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_out,
    output logic key_press,
    output logic key_release
);

    localparam int DEB_CNT = DEB_TIME_NS / CLK_CYC;
    localparam int CNT_W   = deb_cnt_width(DEB_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT - 1);

    generate
        if (DEB_CNT < 2) begin : g_deb_cnt_check
            $error("key_debounce: DEB_TIME_NS/CLK_CYC must be at least 2");
        end
    endgenerate

    logic             w_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_key;
    logic             r_press;
    logic             r_release;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .i_clk  (sysclk),
        .i_srst (sys_rst),
        .i_d    (key_in),
        .o_q    (w_s2)
    );

    // Any sample that agrees with the current output restarts qualification.
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            r_cnt     <= '0;
            r_key     <= 1'b1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_s2 == r_key) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_key     <= w_s2;
                r_cnt     <= '0;
                r_press   <= ~w_s2;
                r_release <= w_s2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign key_out     = r_key;
    assign key_press   = r_press;
    assign key_release = r_release;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a 100-cycle debounce window.
module tb_key_debounce;

    localparam int CLK_CYC     = 10;
    localparam int DEB_TIME_NS = 1000;
    localparam int DEB_CNT     = 100;
    // E0 is edge 1 of every run, so the output moves at edge 1+1+DEB_CNT.
    localparam int CHG_EDGE    = 2 + DEB_CNT;

    logic sysclk;
    logic sys_rst;
    logic key_in;
    logic key_out;
    logic key_press;
    logic key_release;

    int n_tests;
    int n_fail;

    key_debounce #(
        .CLK_CYC     (CLK_CYC),
        .DEB_TIME_NS (DEB_TIME_NS)
    ) dut (
        .sysclk      (sysclk),
        .sys_rst     (sys_rst),
        .key_in      (key_in),
        .key_out     (key_out),
        .key_press   (key_press),
        .key_release (key_release)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Drives key_in = lvl for the first `hold` edges then ~lvl, for `window` edges.
    // Reports the first edge index where key_out moved and strobe statistics.
    task automatic run(input logic lvl, input int hold, input int window, input int rst_at,
                       output int chg, output int np, output int nr,
                       output logic strb_at_chg, output int nbad);
        logic start;
        logic prev_s;
        start = key_out;
        chg = -1; np = 0; nr = 0; nbad = 0;
        strb_at_chg = 1'b0;
        prev_s = 1'b0;
        for (int i = 1; i <= window; i++) begin
            @(negedge sysclk);
            key_in  = (i <= hold) ? lvl : ~lvl;
            sys_rst = (i == rst_at);
            @(posedge sysclk);
            #1;
            if (key_press)   np++;
            if (key_release) nr++;
            if ((key_press && key_release) || ((key_press || key_release) && prev_s)) nbad++;
            prev_s = key_press | key_release;
            if (chg < 0 && key_out !== start) begin
                chg = i;
                strb_at_chg = start ? key_press : key_release;
            end
        end
        @(negedge sysclk);
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        key_in  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge sysclk);
            #1;
            n_tests++;
            if (key_out !== 1'b1) begin
                n_fail++; $display("FAIL reset_key_out cycle %0d: got %b want 1", c, key_out);
            end
            n_tests++;
            if (key_press !== 1'b0) begin
                n_fail++; $display("FAIL reset_press cycle %0d: got %b want 0", c, key_press);
            end
            n_tests++;
            if (key_release !== 1'b0) begin
                n_fail++; $display("FAIL reset_release cycle %0d: got %b want 0", c, key_release);
            end
            n_tests++;
            if (dut.r_cnt !== '0) begin
                n_fail++; $display("FAIL reset_cnt cycle %0d: got %0d want 0", c, dut.r_cnt);
            end
        end
        @(negedge sysclk);
        key_in  = 1'b1;
        sys_rst = 1'b0;
        repeat (5) @(posedge sysclk);
        #1;
        n_tests++;
        if (key_out !== 1'b1) begin
            n_fail++; $display("FAIL reset_idle_key_out: got %b want 1", key_out);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_press();
        int chg, np, nr, nbad;
        logic sac;
        run(1'b0, 200, 200, 0, chg, np, nr, sac, nbad);
        n_tests++;
        if (chg !== CHG_EDGE) begin
            n_fail++; $display("FAIL press_latency: got edge %0d want %0d", chg, CHG_EDGE);
        end
        n_tests++;
        if (np !== 1 || sac !== 1'b1) begin
            n_fail++; $display("FAIL press_strobe: got %0d pulses (at change %b) want 1 (1)", np, sac);
        end
        n_tests++;
        if (nr !== 0 || nbad !== 0) begin
            n_fail++; $display("FAIL press_no_release: got release %0d bad %0d want 0 0", nr, nbad);
        end
        n_tests++;
        if (key_out !== 1'b0) begin
            n_fail++; $display("FAIL press_level: got %b want 0", key_out);
        end
        $display("[TB] test_press change edge %0d", chg);
    endtask

    task automatic test_release();
        int chg, np, nr, nbad;
        logic sac;
        run(1'b1, 200, 200, 0, chg, np, nr, sac, nbad);
        n_tests++;
        if (chg !== CHG_EDGE) begin
            n_fail++; $display("FAIL release_latency: got edge %0d want %0d", chg, CHG_EDGE);
        end
        n_tests++;
        if (nr !== 1 || sac !== 1'b1 || np !== 0 || nbad !== 0) begin
            n_fail++; $display("FAIL release_strobe: got rel %0d press %0d at_chg %b bad %0d want 1 0 1 0",
                               nr, np, sac, nbad);
        end
        n_tests++;
        if (key_out !== 1'b1) begin
            n_fail++; $display("FAIL release_level: got %b want 1", key_out);
        end
        $display("[TB] test_release change edge %0d", chg);
    endtask

    task automatic test_bounce();
        int seeds [4];
        int chg, np, nr, nbad;
        int tot_np, tot_nr, tot_chg;
        int h;
        logic sac;
        logic lvl;
        seeds = '{10, 11, 13, 15};
        tot_np = 0; tot_nr = 0; tot_chg = 0;
        lvl = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int unsigned r;
            r = $urandom(seeds[k]);
            h = 1 + int'(r % 99);
            run(lvl, h, h, 0, chg, np, nr, sac, nbad);
            tot_np += np;
            tot_nr += nr;
            if (chg >= 0) tot_chg++;
            $display("[TB] bounce toggle %0d level %b hold %0d ns", k, lvl, h * CLK_CYC);
            lvl = ~lvl;
        end
        n_tests++;
        if (tot_np !== 0 || tot_nr !== 0 || tot_chg !== 0) begin
            n_fail++; $display("FAIL bounce_filter: got press %0d rel %0d changes %0d want 0 0 0",
                               tot_np, tot_nr, tot_chg);
        end
        run(1'b0, 200, 200, 0, chg, np, nr, sac, nbad);
        n_tests++;
        if (chg !== CHG_EDGE) begin
            n_fail++; $display("FAIL bounce_settle_latency: got edge %0d want %0d", chg, CHG_EDGE);
        end
        n_tests++;
        if (np !== 1 || nr !== 0 || sac !== 1'b1) begin
            n_fail++; $display("FAIL bounce_settle_strobe: got press %0d rel %0d at_chg %b want 1 0 1",
                               np, nr, sac);
        end
        // Return to released for the following tests.
        run(1'b1, 200, 200, 0, chg, np, nr, sac, nbad);
        n_tests++;
        if (key_out !== 1'b1) begin
            n_fail++; $display("FAIL bounce_restore: got %b want 1", key_out);
        end
        $display("[TB] test_bounce settle edge %0d", chg);
    endtask

    task automatic test_boundary();
        int chg, np, nr, nbad;
        logic sac;
        run(1'b0, DEB_CNT - 1, 150, 0, chg, np, nr, sac, nbad);
        n_tests++;
        if (chg !== -1 || np !== 0 || nr !== 0 || key_out !== 1'b1) begin
            n_fail++; $display("FAIL glitch_short: got chg %0d press %0d rel %0d out %b want -1 0 0 1",
                               chg, np, nr, key_out);
        end
        run(1'b0, DEB_CNT + 1, 250, 0, chg, np, nr, sac, nbad);
        n_tests++;
        if (chg !== CHG_EDGE || np !== 1 || nr !== 1 || nbad !== 0) begin
            n_fail++; $display("FAIL glitch_long: got chg %0d press %0d rel %0d bad %0d want %0d 1 1 0",
                               chg, np, nr, nbad, CHG_EDGE);
        end
        n_tests++;
        if (key_out !== 1'b1) begin
            n_fail++; $display("FAIL glitch_long_end: got %b want 1", key_out);
        end
        $display("[TB] test_boundary long-pulse change edge %0d", chg);
    endtask

    task automatic test_reset_mid_count();
        localparam int RST_EDGE = 52;
        int chg, np, nr, nbad;
        logic sac;
        run(1'b0, 250, 250, RST_EDGE, chg, np, nr, sac, nbad);
        n_tests++;
        if (chg !== RST_EDGE + 2 + DEB_CNT) begin
            n_fail++; $display("FAIL rst_mid_latency: got edge %0d want %0d", chg, RST_EDGE + 2 + DEB_CNT);
        end
        n_tests++;
        if (np !== 1 || nr !== 0 || key_out !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_strobe: got press %0d rel %0d out %b want 1 0 0",
                               np, nr, key_out);
        end
        $display("[TB] test_reset_mid_count change edge %0d", chg);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        sys_rst = 1'b1;
        key_in  = 1'b0;
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_boundary();
        test_reset_mid_count();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
